mem_port_arbiter: RTL and testbench

//   Shares one single-ported unified memory between the fetch stage (IF port) and the

---
 rtl/rv32i_mem_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared encodings and default limits for the unified-memory port arbiter.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } src_t;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 15;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (IF) and load/store (DM) ports onto one single-ported memory,
// with DM priority, an IF anti-starvation limit, a bus timeout and the core stall.
module mem_port_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ack,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_ack,
  output logic            bus_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            stall_core
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LIM    = TW'(TIMEOUT);

  state_t        state, state_next;
  src_t          grant_src, win;
  logic          err;
  logic          grant, mem_done, tmo_hit;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt, tmo_inc;

  always_comb begin
    state_next = state;
    win        = SRC_DM;
    grant      = 1'b0;
    mem_done   = 1'b0;
    tmo_hit    = 1'b0;
    tmo_inc    = tmo_cnt + TW'(1);
    case (state)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          grant      = 1'b1;
          state_next = ST_BUSY;
          // DM wins ties unless IF has waited out STARVE_MAX DM grants
          if (dm_req && !(if_req && starve_cnt == STARVE_LIM)) win = SRC_DM;
          else                                                 win = SRC_IF;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          mem_done   = 1'b1;
          state_next = ST_RESP;
        end else if (tmo_inc == TMO_LIM) begin
          tmo_hit    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant_src  <= SRC_IF;
      err        <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        mem_en    <= 1'b1;
        grant_src <= win;
        err       <= 1'b0;
        tmo_cnt   <= '0;
        if (win == SRC_IF) begin
          mem_we     <= 1'b0;
          mem_addr   <= if_addr;
          mem_wdata  <= '0;
          starve_cnt <= '0;
        end else begin
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          if (!if_req)                       starve_cnt <= '0;
          else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + SW'(1);
        end
      end
      if (mem_done) begin
        mem_en <= 1'b0;
        if (grant_src == SRC_IF) if_rdata <= mem_rdata;
        else if (!mem_we)        dm_rdata <= mem_rdata;
      end
      if (state == ST_BUSY && !mem_ready && !tmo_hit) tmo_cnt <= tmo_inc;
      if (tmo_hit) begin
        mem_en <= 1'b0;
        err    <= 1'b1;
      end
    end
  end

  assign if_ack     = (state == ST_RESP) && (grant_src == SRC_IF);
  assign dm_ack     = (state == ST_RESP) && (grant_src == SRC_DM);
  assign bus_err    = (state == ST_RESP) && err;
  assign stall_core = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single-port transactions plus
// hand-written collision, starvation and reset-during-access sequences.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack, bus_err;
  logic        mem_en, mem_we, mem_ready, stall_core;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.XLEN(32), .STARVE_MAX(4), .TIMEOUT(15)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .bus_err(bus_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_core(stall_core)
  );

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   busy;
    int   ack_cyc;
    logic seen_en;
    @(posedge CLK); #1;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    mem_rdata = v.rdata;
    busy = 0; ack_cyc = -1; seen_en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (c == 0) chk("stall_req", 32'(stall_core), 32'd1);
      if (mem_en) begin
        if (!seen_en) begin
          seen_en = 1'b1;
          chk("mem_en_cycle", 32'(c), 32'd1);
          chk("mem_we", 32'(mem_we), 32'(v.is_dm & v.we));
          chk("mem_addr", mem_addr, v.addr);
          if (v.is_dm && v.we) chk("mem_wdata", mem_wdata, v.wdata);
        end
        mem_ready = (busy == v.delay);
        busy++;
      end else begin
        mem_ready = 1'b0;
      end
      if (if_ack || dm_ack) begin
        ack_cyc = c;
        chk("ack_port", 32'({dm_ack, if_ack}), v.is_dm ? 32'd2 : 32'd1);
        chk("bus_err", 32'(bus_err), 32'(v.exp_err));
        chk("mem_en_in_resp", 32'(mem_en), 32'd0);
        chk("rdata", v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        break;
      end
    end
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    chk("ack_latency", 32'(ack_cyc), 32'(v.lat));
    @(negedge CLK);
    chk("stall_after_ack", 32'(stall_core), 32'd0);
    chk("no_ack_after", 32'({dm_ack, if_ack}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] order[2];
    int         n;
    int         both;
    int         ack_at;
    logic       first;

    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        32'h00500093, 0,  2,  32'h00500093, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h2000, 32'h0,        32'h11223344, 3,  5,  32'h11223344, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h2004, 32'hCAFEF00D, 32'h55555555, 0,  2,  32'h11223344, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h104,  32'h0,        32'h99999999, 99, 16, 32'h00500093, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h3000, 32'h0,        32'h77777777, 99, 16, 32'h11223344, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h108,  32'h0,        32'h00A00113, 1,  3,  32'h00A00113, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h2008, 32'h0,        32'hA5A5A5A5, 0,  2,  32'hA5A5A5A5, 1'b0};

    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    #12;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_acks", 32'({dm_ack, if_ack}), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall_core), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Collision: DM store wins, IF follows; dm_rdata untouched by the store
    @(posedge CLK); #1;
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h100;
    n = 0; first = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (mem_en && first) begin
        first = 1'b0;
        chk("col_mem_we", 32'(mem_we), 32'd1);
        chk("col_mem_addr", mem_addr, 32'h2000);
        chk("col_mem_wdata", mem_wdata, 32'hDEADBEEF);
      end
      if (dm_ack || if_ack) begin
        order[n] = {dm_ack, if_ack};
        n++;
        if (dm_ack) dm_req = 1'b0;
        if (if_ack) if_req = 1'b0;
        if (n == 2) break;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("col_ack_count", 32'(n), 32'd2);
    chk("col_first_dm", 32'(order[0]), 32'd2);
    chk("col_second_if", 32'(order[1]), 32'd1);
    chk("col_dm_rdata", dm_rdata, 32'hA5A5A5A5);
    chk("col_if_rdata", if_rdata, 32'h0BADF00D);

    // Both held: four DM grants, then IF is forced, repeating
    @(posedge CLK); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2010; if_req = 1'b1; if_addr = 32'h10C;
    mem_rdata = 32'h12345678;
    n = 0; both = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge CLK);
      if (dm_ack && if_ack) both++;
      if (dm_ack || if_ack) begin
        chk("starve_seq", 32'({dm_ack, if_ack}), (n % 5 == 4) ? 32'd1 : 32'd2);
        n++;
        if (n == 15) begin
          dm_req = 1'b0; if_req = 1'b0;
          break;
        end
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    chk("starve_ack_count", 32'(n), 32'd15);
    chk("starve_no_dual_ack", 32'(both), 32'd0);
    chk("starve_dm_rdata", dm_rdata, 32'h12345678);
    @(negedge CLK);
    @(negedge CLK);

    // Reset during BUSY: mem_en drops at once, no ack, held req re-granted
    @(posedge CLK); #1;
    mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h200; mem_rdata = 32'h00000013;
    first = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (mem_en) begin first = 1'b1; break; end
    end
    chk("rstb_busy_seen", 32'(first), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstb_mem_en_async", 32'(mem_en), 32'd0);
    chk("rstb_no_ack", 32'({dm_ack, if_ack}), 32'd0);
    @(negedge CLK);
    chk("rstb_if_rdata", if_rdata, 32'd0);
    chk("rstb_stall_held", 32'(stall_core), 32'd1);
    rst_n = 1'b1; mem_ready = 1'b1;
    ack_at = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (if_ack) begin ack_at = c; break; end
    end
    if_req = 1'b0; mem_ready = 1'b0;
    chk("rstb_regrant_ack", 32'(ack_at), 32'd1);
    chk("rstb_if_rdata_new", if_rdata, 32'h00000013);
    @(negedge CLK);
    chk("rstb_idle_after", 32'({mem_en, dm_ack, if_ack}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
